// File: rtl/guess_scorer.sv
// Iterative Mastermind scorer: 4 exact-compare cycles, then 16 partial-compare cycles, then a FINISH cycle.
// Result and done are visible 21 edges after start is sampled; start is ignored while busy, clear aborts.
module guess_scorer #(
  parameter logic [6:0] HEX_BLANK = 7'h7F
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] target [3:0],
  input  logic [3:0] guess  [3:0],
  output logic       busy,
  output logic       done,
  output logic [2:0] exact,
  output logic [2:0] partial,
  output logic       win,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  typedef enum logic [1:0] {S_IDLE, S_EXACT, S_PARTIAL, S_FINISH} state_t;

  state_t     state_q, state_d;
  logic [3:0] t_s_q [4];
  logic [3:0] t_s_d [4];
  logic [3:0] g_s_q [4];
  logic [3:0] g_s_d [4];
  logic [3:0] ut_q, ut_d, ug_q, ug_d;
  logic [1:0] i_q, i_d, j_q, j_d;
  logic [2:0] ex_w_q, ex_w_d, pa_w_q, pa_w_d;
  logic [2:0] exact_q, exact_d, partial_q, partial_d;
  logic       shown_q, shown_d, done_q, done_d;

  function automatic logic [6:0] seg(input logic [2:0] v);
    case (v)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      default: seg = HEX_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    t_s_d     = t_s_q;
    g_s_d     = g_s_q;
    ut_d      = ut_q;
    ug_d      = ug_q;
    i_d       = i_q;
    j_d       = j_q;
    ex_w_d    = ex_w_q;
    pa_w_d    = pa_w_q;
    exact_d   = exact_q;
    partial_d = partial_q;
    shown_d   = shown_q;
    done_d    = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      exact_d   = 3'd0;
      partial_d = 3'd0;
      shown_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            t_s_d   = target;
            g_s_d   = guess;
            ut_d    = 4'd0;
            ug_d    = 4'd0;
            ex_w_d  = 3'd0;
            pa_w_d  = 3'd0;
            i_d     = 2'd0;
            j_d     = 2'd0;
            state_d = S_EXACT;
          end
        end
        S_EXACT: begin
          if (t_s_q[i_q] == g_s_q[i_q]) begin
            ex_w_d     = ex_w_q + 3'd1;
            ut_d[i_q]  = 1'b1;
            ug_d[i_q]  = 1'b1;
          end
          i_d = i_q + 2'd1;
          if (i_q == 2'd3) begin
            j_d     = 2'd0;
            state_d = S_PARTIAL;
          end
        end
        S_PARTIAL: begin
          // i walks the guess (outer), j walks the target (inner)
          if (!ug_q[i_q] && !ut_q[j_q] && g_s_q[i_q] == t_s_q[j_q]) begin
            pa_w_d    = pa_w_q + 3'd1;
            ug_d[i_q] = 1'b1;
            ut_d[j_q] = 1'b1;
          end
          j_d = j_q + 2'd1;
          if (j_q == 2'd3) begin
            i_d = i_q + 2'd1;
            if (i_q == 2'd3) state_d = S_FINISH;
          end
        end
        S_FINISH: begin
          exact_d   = ex_w_q;
          partial_d = pa_w_q;
          shown_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < 4; k++) begin
        t_s_q[k] <= 4'd0;
        g_s_q[k] <= 4'd0;
      end
      ut_q      <= 4'd0;
      ug_q      <= 4'd0;
      i_q       <= 2'd0;
      j_q       <= 2'd0;
      ex_w_q    <= 3'd0;
      pa_w_q    <= 3'd0;
      exact_q   <= 3'd0;
      partial_q <= 3'd0;
      shown_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_s_q     <= t_s_d;
      g_s_q     <= g_s_d;
      ut_q      <= ut_d;
      ug_q      <= ug_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ex_w_q    <= ex_w_d;
      pa_w_q    <= pa_w_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      shown_q   <= shown_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign exact   = exact_q;
  assign partial = partial_q;
  assign win     = shown_q && (exact_q == 3'd4);
  assign HEX1    = shown_q ? seg(exact_q)   : HEX_BLANK;
  assign HEX0    = shown_q ? seg(partial_q) : HEX_BLANK;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: latency, Mastermind scoring, display decode, start/clear/reset interactions.
module tb_guess_scorer;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic       clear    = 1'b0;
  logic [3:0] target [3:0];
  logic [3:0] guess  [3:0];
  logic       busy, done, win;
  logic [2:0] exact, partial;
  logic [6:0] HEX1, HEX0;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG0  = 7'b1000000;
  localparam logic [6:0] SEG1  = 7'b1111001;
  localparam logic [6:0] SEG2  = 7'b0100100;
  localparam logic [6:0] SEG4  = 7'b0011001;

  guess_scorer #(.HEX_BLANK(7'h7F)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .clear(clear),
    .target(target), .guess(guess), .busy(busy), .done(done),
    .exact(exact), .partial(partial), .win(win), .HEX1(HEX1), .HEX0(HEX0)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // tv/gv digits are written left to right: [15:12] is index 0
  task automatic set_digits(input logic [15:0] tv, input logic [15:0] gv);
    for (int k = 0; k < 4; k++) begin
      target[k] = tv[15-4*k -: 4];
      guess[k]  = gv[15-4*k -: 4];
    end
  endtask

  // pulses start into E0, returns edges until done is seen (-1 if never)
  task automatic run_score(output int lat);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    set_digits(16'h0000, 16'h0000);
    #25;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (exact !== 3'd0)   begin bad++; $display("FAIL reset_exact got=%0d exp=0", exact); end
    total++; if (partial !== 3'd0) begin bad++; $display("FAIL reset_partial got=%0d exp=0", partial); end
    total++; if (win !== 1'b0)     begin bad++; $display("FAIL reset_win got=%b exp=0", win); end
    total++; if (HEX1 !== BLANK)   begin bad++; $display("FAIL reset_hex1 got=%b exp=%b", HEX1, BLANK); end
    total++; if (HEX0 !== BLANK)   begin bad++; $display("FAIL reset_hex0 got=%b exp=%b", HEX0, BLANK); end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_exact_match;
    int lat;
    set_digits(16'h1234, 16'h1234);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_e0 got=%b exp=1", busy); end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin lat = c; break; end
    end
    total++; if (lat != 21)        begin bad++; $display("FAIL exact_latency got=%0d exp=21", lat); end
    total++; if (exact !== 3'd4)   begin bad++; $display("FAIL exact4_exact got=%0d exp=4", exact); end
    total++; if (partial !== 3'd0) begin bad++; $display("FAIL exact4_partial got=%0d exp=0", partial); end
    total++; if (win !== 1'b1)     begin bad++; $display("FAIL exact4_win got=%b exp=1", win); end
    total++; if (HEX1 !== SEG4)    begin bad++; $display("FAIL exact4_hex1 got=%b exp=%b", HEX1, SEG4); end
    total++; if (HEX0 !== SEG0)    begin bad++; $display("FAIL exact4_hex0 got=%b exp=%b", HEX0, SEG0); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL exact4_busy_at_e21 got=%b exp=0", busy); end
    @(posedge CLOCK_50); #1;
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL done_width got=%b exp=0", done); end
  endtask

  task automatic test_reverse;
    int lat;
    set_digits(16'h1234, 16'h4321);
    run_score(lat);
    total++; if (lat != 21)        begin bad++; $display("FAIL rev_latency got=%0d exp=21", lat); end
    total++; if (exact !== 3'd0)   begin bad++; $display("FAIL rev_exact got=%0d exp=0", exact); end
    total++; if (partial !== 3'd4) begin bad++; $display("FAIL rev_partial got=%0d exp=4", partial); end
    total++; if (win !== 1'b0)     begin bad++; $display("FAIL rev_win got=%b exp=0", win); end
    total++; if (HEX0 !== SEG4)    begin bad++; $display("FAIL rev_hex0 got=%b exp=%b", HEX0, SEG4); end
  endtask

  task automatic test_duplicates;
    int lat;
    set_digits(16'h1123, 16'h1311);
    run_score(lat);
    total++; if (exact !== 3'd1)   begin bad++; $display("FAIL dup_exact got=%0d exp=1", exact); end
    total++; if (partial !== 3'd2) begin bad++; $display("FAIL dup_partial got=%0d exp=2", partial); end
    total++; if (HEX1 !== SEG1)    begin bad++; $display("FAIL dup_hex1 got=%b exp=%b", HEX1, SEG1); end
    total++; if (HEX0 !== SEG2)    begin bad++; $display("FAIL dup_hex0 got=%b exp=%b", HEX0, SEG2); end
    // high nibble values compare like any other digit
    set_digits(16'hAF33, 16'hFA30);
    run_score(lat);
    total++; if (exact !== 3'd1)   begin bad++; $display("FAIL hexdig_exact got=%0d exp=1", exact); end
    total++; if (partial !== 3'd2) begin bad++; $display("FAIL hexdig_partial got=%0d exp=2", partial); end
  endtask

  task automatic test_no_match;
    int lat;
    set_digits(16'h1234, 16'h5678);
    run_score(lat);
    total++; if (exact !== 3'd0)   begin bad++; $display("FAIL none_exact got=%0d exp=0", exact); end
    total++; if (partial !== 3'd0) begin bad++; $display("FAIL none_partial got=%0d exp=0", partial); end
    total++; if (HEX1 !== SEG0)    begin bad++; $display("FAIL none_hex1 got=%b exp=%b", HEX1, SEG0); end
    total++; if (HEX0 !== SEG0)    begin bad++; $display("FAIL none_hex0 got=%b exp=%b", HEX0, SEG0); end
  endtask

  task automatic test_restart_ignored;
    int pulses;
    int first;
    set_digits(16'h1234, 16'h1243);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    pulses = 0;
    first = -1;
    for (int c = 1; c <= 50; c++) begin
      if (c == 5) start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == 22 && busy !== 1'b0) begin
        total++; bad++; $display("FAIL restart_busy_e22 got=%b exp=0", busy);
      end
    end
    total++; if (pulses != 1)      begin bad++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
    total++; if (first != 21)      begin bad++; $display("FAIL restart_latency got=%0d exp=21", first); end
    total++; if (exact !== 3'd2)   begin bad++; $display("FAIL restart_exact got=%0d exp=2", exact); end
    total++; if (partial !== 3'd2) begin bad++; $display("FAIL restart_partial got=%0d exp=2", partial); end
  endtask

  task automatic test_snapshot;
    int lat;
    set_digits(16'h1234, 16'h1234);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLOCK_50); #1;
      if (c == 3) set_digits(16'h9999, 16'h5678);
      if (done) begin lat = c; break; end
    end
    total++; if (lat != 21)        begin bad++; $display("FAIL snap_latency got=%0d exp=21", lat); end
    total++; if (exact !== 3'd4)   begin bad++; $display("FAIL snap_exact got=%0d exp=4", exact); end
    total++; if (win !== 1'b1)     begin bad++; $display("FAIL snap_win got=%b exp=1", win); end
  endtask

  task automatic test_clear;
    int pulses;
    set_digits(16'h1234, 16'h4321);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) clear = 1'b1;
      @(posedge CLOCK_50); #1;
      clear = 1'b0;
      if (done) pulses++;
      if (c == 11) begin
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL clear_busy got=%b exp=0", busy); end
        total++; if (exact !== 3'd0)   begin bad++; $display("FAIL clear_exact got=%0d exp=0", exact); end
        total++; if (partial !== 3'd0) begin bad++; $display("FAIL clear_partial got=%0d exp=0", partial); end
        total++; if (HEX1 !== BLANK)   begin bad++; $display("FAIL clear_hex1 got=%b exp=%b", HEX1, BLANK); end
        total++; if (HEX0 !== BLANK)   begin bad++; $display("FAIL clear_hex0 got=%b exp=%b", HEX0, BLANK); end
        total++; if (win !== 1'b0)     begin bad++; $display("FAIL clear_win got=%b exp=0", win); end
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL clear_done_pulses got=%0d exp=0", pulses); end
    // clear and start together in IDLE: start is dropped
    start = 1'b1;
    clear = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_vs_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset;
    int lat;
    set_digits(16'h1234, 16'h1234);
    run_score(lat);
    set_digits(16'h1234, 16'h2134);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (7) @(posedge CLOCK_50);
    #5;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (exact !== 3'd0)   begin bad++; $display("FAIL arst_exact got=%0d exp=0", exact); end
    total++; if (win !== 1'b0)     begin bad++; $display("FAIL arst_win got=%b exp=0", win); end
    total++; if (HEX1 !== BLANK)   begin bad++; $display("FAIL arst_hex1 got=%b exp=%b", HEX1, BLANK); end
    total++; if (HEX0 !== BLANK)   begin bad++; $display("FAIL arst_hex0 got=%b exp=%b", HEX0, BLANK); end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    run_score(lat);
    total++; if (lat != 21)        begin bad++; $display("FAIL post_rst_latency got=%0d exp=21", lat); end
    total++; if (exact !== 3'd2)   begin bad++; $display("FAIL post_rst_exact got=%0d exp=2", exact); end
    total++; if (partial !== 3'd2) begin bad++; $display("FAIL post_rst_partial got=%0d exp=2", partial); end
  endtask

  task automatic test_back_to_back;
    int lat;
    set_digits(16'h1234, 16'h1234);
    run_score(lat);
    // start now lands on E22 of the previous run
    set_digits(16'h1234, 16'h5634);
    run_score(lat);
    total++; if (lat != 21)        begin bad++; $display("FAIL b2b_latency got=%0d exp=21", lat); end
    total++; if (exact !== 3'd2)   begin bad++; $display("FAIL b2b_exact got=%0d exp=2", exact); end
    total++; if (partial !== 3'd0) begin bad++; $display("FAIL b2b_partial got=%0d exp=0", partial); end
  endtask

  initial begin
    test_reset;
    test_exact_match;
    test_reverse;
    test_duplicates;
    test_no_match;
    test_restart_ignored;
    test_snapshot;
    test_clear;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_scorer.md
# guess_scorer

Scores a player's 4-digit guess against the 4-digit target and shows the result on the two unused displays, HEX1 (exact hits) and HEX0 (misplaced hits). It sits downstream of game_core and beside display_ctrl in DE1_SoC, taking the same `target` and `guess` digit arrays. It is a multi-cycle iterative comparator with a start/busy/done handshake. Duplicate digits are handled with standard Mastermind matching: each target digit and each guess digit is consumed at most once.

## Interface
- `HEX_BLANK`, default 7'h7F: active-low segment pattern for a blank digit.
- `CLOCK_50` in 1: system clock, 50 MHz.
- `reset_n` in 1: reset, asynchronous, active-low; clock CLOCK_50.
- `start` in 1: one-cycle request to score the current `guess` against `target`.
- `clear` in 1: one-cycle request to abort any scoring and blank the result.
- `target` in [3:0] x4 (`logic [3:0] target [3:0]`): target digits; index 0 is the leftmost digit.
- `guess` in [3:0] x4: guess digits, same indexing.
- `busy` out 1: high while scoring is in progress.
- `done` out 1: one-cycle pulse when new results are valid.
- `exact` out 3: count of digits matching in both value and position, 0..4.
- `partial` out 3: count of digits matching in value but not position, 0..4.
- `win` out 1: high when `exact == 4`.
- `HEX1`, `HEX0` out 7 each: active-low 7-seg output; HEX1 shows `exact`, HEX0 shows `partial`.

## Operation
- States are IDLE, EXACT, PARTIAL and FINISH.
- Internal registers:
  - snapshot copies `t_s[3:0]` and `g_s[3:0]`;
  - used flags `ut[3:0]` and `ug[3:0]`;
  - 2-bit indices `i` and `j`;
  - 3-bit working counters `ex_w` and `pa_w`;
  - a `shown` flag.
- IDLE, when `start` is high:
  - snapshot `target`/`guess` into `t_s`/`g_s`;
  - clear `ut`, `ug`, `ex_w`, `pa_w`, `i` and `j`;
  - go to EXACT.
- EXACT (one index per cycle, i = 0..3):
  - if `t_s[i] == g_s[i]`: `ex_w++` and set `ut[i]` and `ug[i]`;
  - after i = 3, go to PARTIAL with i = j = 0.
- PARTIAL (one (i, j) pair per cycle, i = guess index as outer loop, j = target index as inner loop, 16 cycles):
  - if `!ug[i] && !ut[j] && g_s[i] == t_s[j]`: `pa_w++` and set `ug[i]` and `ut[j]`;
  - after (3,3), go to FINISH.
- FINISH:
  - `exact <= ex_w`, `partial <= pa_w`, `shown <= 1`;
  - `done <= 1` for exactly one cycle;
  - return to IDLE.
- Any 4-bit value is a legal digit. Comparison is plain 4-bit equality, so 0xA..0xF compare normally.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- `start` received while busy is ignored. It is not queued.
- `clear`:
  - takes priority over `start` and over every state;
  - next state IDLE, `exact = partial = 0`, `shown = 0`, no `done` pulse.
- Display and win outputs:
  - `win` = `shown && exact == 4`;
  - when `shown` is 0, HEX1 and HEX0 both show `HEX_BLANK`;
  - segment codes (active-low, gfedcba): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001;
  - values above 4 cannot occur and decode to `HEX_BLANK`.
- Inputs that change after the snapshot do not affect the result in progress.

## Timing
- Reset values:
  - state IDLE, `busy = 0`, `done = 0`, `exact = 0`, `partial = 0`, `win = 0`;
  - `shown = 0`, so HEX1 = HEX0 = `HEX_BLANK`;
  - all internal registers 0.
- Reset asserted mid-scoring aborts immediately (asynchronously), with no `done` pulse.
- Let E0 be the clock edge that samples `start`.
- Edges E1..E4 are EXACT and E5..E20 are PARTIAL.
- Edge E21 is FINISH: `done` is high from E21 to E22, and the new `exact`/`partial`/`win`/HEX values are visible from E21 onward.
- `busy` is high from E0 to E21, i.e. 21 cycles.
- A `start` sampled at E22 or later is accepted. Back-to-back throughput is one score per 22 cycles.
- `exact`/`partial` hold their last values between scores, including during a new scoring run, until the next FINISH or a `clear`.
- `clear` and `start` in the same IDLE cycle: clear wins and the start is dropped.

## Test plan
- Target 1,2,3,4 and guess 1,2,3,4; pulse `start`:
  - `done` pulses exactly 21 cycles after the start-sampling edge;
  - exact = 4, partial = 0, win = 1;
  - HEX1 = 0011001, HEX0 = 1000000.
- Target 1,2,3,4 and guess 4,3,2,1: exact = 0, partial = 4, win = 0.
- Duplicates, target 1,1,2,3 and guess 1,3,1,1: exact = 1, partial = 2 (a guess 1 is not double-counted).
- Target 1,2,3,4 and guess 5,6,7,8: exact = 0, partial = 0, and both HEX outputs show 1000000 (not blank).
- Start/clear interactions:
  - `start` re-pulsed at E5 is ignored, with exactly one `done` pulse;
  - guess changed at E3 still yields the score of the snapshotted guess;
  - `clear` at E10 gives no `done`, exact = partial = 0, HEX blank, busy = 0 at E11.
- `reset_n` low at E8 drives all outputs to reset values asynchronously; a subsequent start scores correctly.
